// File: rtl/mastermind_pkg.sv
// Shared types and default geometry for the Mastermind grader.
package mastermind_pkg;

    localparam int unsigned DEF_NUM_PEGS = 4;
    localparam int unsigned DEF_COLOR_W  = 3;

    typedef logic [DEF_COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        TALLY = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/peg_histogram.sv
// Per-colour occurrence counters: synchronous clear, increment at one index,
// combinational read at another index.
module peg_histogram #(
    parameter int unsigned COLOR_W = 3,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic [COLOR_W-1:0] inc_idx_i,
    input  logic [COLOR_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0]   rd_cnt_o
);

    localparam int unsigned NUM_COLORS = 2**COLOR_W;

    logic [CNT_W-1:0] cnt_q [NUM_COLORS];
    logic [CNT_W-1:0] cnt_d [NUM_COLORS];

    assign rd_cnt_o = cnt_q[rd_idx_i];

    // Next counter values: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            for (int unsigned c = 0; c < NUM_COLORS; c++) begin
                cnt_d[c] = '0;
            end
        end else if (inc_i) begin
            cnt_d[inc_idx_i] = cnt_q[inc_idx_i] + CNT_W'(1);
        end
    end

    // Counter storage with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_COLORS; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mastermind_grader_seq.sv
// Sequential Mastermind grader: scans pegs one per cycle into guess/pattern
// colour histograms, then tallies white pegs one colour per cycle.
module mastermind_grader_seq
    import mastermind_pkg::*;
#(
    parameter  int unsigned NUM_PEGS   = DEF_NUM_PEGS,
    parameter  int unsigned COLOR_W    = DEF_COLOR_W,
    localparam int unsigned NUM_COLORS = 2**COLOR_W,
    localparam int unsigned CNT_W      = $clog2(NUM_PEGS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_PEGS*COLOR_W-1:0] guess,
    input  logic [NUM_PEGS*COLOR_W-1:0] pattern,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            red,
    output logic [CNT_W-1:0]            white,
    output logic                        win
);

    localparam int unsigned IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
    localparam int unsigned ROW_W = NUM_PEGS * COLOR_W;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   guess_q, guess_d;
    logic [ROW_W-1:0]   pattern_q, pattern_d;
    logic [IDX_W-1:0]   peg_q, peg_d;
    logic [COLOR_W-1:0] col_q, col_d;
    logic [CNT_W-1:0]   red_acc_q, red_acc_d;
    logic [CNT_W-1:0]   white_acc_q, white_acc_d;
    logic [CNT_W-1:0]   red_q, red_d;
    logic [CNT_W-1:0]   white_q, white_d;
    logic               win_q, win_d;

    logic               hist_clr, hist_inc;
    logic [COLOR_W-1:0] g_peg, p_peg;
    logic [CNT_W-1:0]   gcnt_rd, pcnt_rd, pair_min;

    assign g_peg    = guess_q[peg_q*COLOR_W +: COLOR_W];
    assign p_peg    = pattern_q[peg_q*COLOR_W +: COLOR_W];
    assign pair_min = (gcnt_rd < pcnt_rd) ? gcnt_rd : pcnt_rd;

    assign red   = red_q;
    assign white = white_q;
    assign win   = win_q;

    peg_histogram #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_guess_hist (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (hist_clr),
        .inc_i     (hist_inc),
        .inc_idx_i (g_peg),
        .rd_idx_i  (col_q),
        .rd_cnt_o  (gcnt_rd)
    );

    peg_histogram #(.COLOR_W(COLOR_W), .CNT_W(CNT_W)) u_pattern_hist (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (hist_clr),
        .inc_i     (hist_inc),
        .inc_idx_i (p_peg),
        .rd_idx_i  (col_q),
        .rd_cnt_o  (pcnt_rd)
    );

    // Next-state, accumulator updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        guess_d     = guess_q;
        pattern_d   = pattern_q;
        peg_d       = peg_q;
        col_d       = col_q;
        red_acc_d   = red_acc_q;
        white_acc_d = white_acc_q;
        red_d       = red_q;
        white_d     = white_q;
        win_d       = win_q;
        hist_clr    = 1'b0;
        hist_inc    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    guess_d     = guess;
                    pattern_d   = pattern;
                    red_acc_d   = '0;
                    white_acc_d = '0;
                    hist_clr    = 1'b1;
                    peg_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (g_peg == p_peg) begin
                    red_acc_d = red_acc_q + CNT_W'(1);
                end else begin
                    hist_inc = 1'b1;
                end
                if (peg_q == IDX_W'(NUM_PEGS - 1)) begin
                    peg_d   = '0;
                    col_d   = '0;
                    state_d = TALLY;
                end else begin
                    peg_d = peg_q + IDX_W'(1);
                end
            end
            TALLY: begin
                white_acc_d = white_acc_q + pair_min;
                col_d       = col_q + COLOR_W'(1);
                if (col_q == '1) begin
                    red_d   = red_acc_q;
                    white_d = white_acc_d;
                    win_d   = (red_acc_q == CNT_W'(NUM_PEGS));
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched job and result registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            guess_q     <= '0;
            pattern_q   <= '0;
            peg_q       <= '0;
            col_q       <= '0;
            red_acc_q   <= '0;
            white_acc_q <= '0;
            red_q       <= '0;
            white_q     <= '0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            guess_q     <= guess_d;
            pattern_q   <= pattern_d;
            peg_q       <= peg_d;
            col_q       <= col_d;
            red_acc_q   <= red_acc_d;
            white_acc_q <= white_acc_d;
            red_q       <= red_d;
            white_q     <= white_d;
            win_q       <= win_d;
        end
    end

endmodule

// File: tb/tb_mastermind_grader_seq.sv
// Directed bench for mastermind_grader_seq at default geometry and at 6 pegs x 2-bit colours.
module tb_mastermind_grader_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Default instance: 4 pegs, 3-bit colours.
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, win;
    logic [11:0] guess = '0, pattern = '0;
    logic [2:0]  red, white;

    // Wide instance: 6 pegs, 2-bit colours.
    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_in_ready, b_out_valid, b_win;
    logic [11:0] b_guess = '0, b_pattern = '0;
    logic [2:0]  b_red, b_white;

    int passed = 0;
    int total  = 0;

    mastermind_grader_seq u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .guess     (guess),
        .pattern   (pattern),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .red       (red),
        .white     (white),
        .win       (win)
    );

    mastermind_grader_seq #(.NUM_PEGS(6), .COLOR_W(2)) u_dut_wide (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .guess     (b_guess),
        .pattern   (b_pattern),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .red       (b_red),
        .white     (b_white),
        .win       (b_win)
    );

    // Peg 0 occupies the least significant bits.
    function automatic logic [11:0] pk4(input logic [2:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic [11:0] pk6(input logic [1:0] p0, p1, p2, p3, p4, p5);
        return {p5, p4, p3, p2, p1, p0};
    endfunction

    // Counts edges after an accept until out_valid; 200 means it never came.
    task automatic wait_a(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clock); lat++; #1;
            if (out_valid) break;
        end
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clock); lat++; #1;
            if (b_out_valid) break;
        end
    endtask

    task automatic job_a(input logic [11:0] g, input logic [11:0] p, output int lat);
        @(negedge clock);
        guess = g; pattern = p; in_valid = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0;
        wait_a(lat);
    endtask

    task automatic job_b(input logic [11:0] g, input logic [11:0] p, output int lat);
        @(negedge clock);
        b_guess = g; b_pattern = p; b_in_valid = 1'b1;
        @(posedge clock); #1 b_in_valid = 1'b0;
        wait_b(lat);
    endtask

    task automatic consume_a;
        @(negedge clock); out_ready = 1'b1;
        @(posedge clock); #1 out_ready = 1'b0;
    endtask

    task automatic consume_b;
        @(negedge clock); b_out_ready = 1'b1;
        @(posedge clock); #1 b_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if ({red, white, win} !== 7'd0) $display("FAIL reset_result got r%0d w%0d win%b want 0/0/0", red, white, win); else passed++;
        total++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) $display("FAIL reset_wide got rdy%b vld%b want 1/0", b_in_ready, b_out_valid); else passed++;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_no_match;
        int lat;
        job_a(pk4(1, 1, 1, 1), pk4(0, 0, 0, 0), lat);
        total++; if (lat !== 12) $display("FAIL nomatch_latency got %0d want 12", lat); else passed++;
        total++; if ({red, white, win} !== {3'd0, 3'd0, 1'b0}) $display("FAIL nomatch_result got r%0d w%0d win%b want 0/0/0", red, white, win); else passed++;
        consume_a();
    endtask

    task automatic test_exact;
        int lat;
        job_a(pk4(1, 1, 1, 1), pk4(1, 1, 1, 1), lat);
        total++; if (lat !== 12) $display("FAIL exact_latency got %0d want 12", lat); else passed++;
        total++; if ({red, white, win} !== {3'd4, 3'd0, 1'b1}) $display("FAIL exact_result got r%0d w%0d win%b want 4/0/1", red, white, win); else passed++;
        consume_a();
    endtask

    task automatic test_duplicates;
        int lat;
        // guess 4,1,1,1 vs pattern 2,4,4,4: only one guess 4 can pair with a pattern 4
        job_a(pk4(4, 1, 1, 1), pk4(2, 4, 4, 4), lat);
        total++; if ({red, white, win} !== {3'd0, 3'd1, 1'b0}) $display("FAIL dup_result got r%0d w%0d win%b want 0/1/0", red, white, win); else passed++;
        consume_a();
    endtask

    task automatic test_all_white;
        int lat;
        job_a(pk4(4, 1, 2, 3), pk4(2, 4, 3, 1), lat);
        total++; if ({red, white, win} !== {3'd0, 3'd4, 1'b0}) $display("FAIL allwhite_result got r%0d w%0d win%b want 0/4/0", red, white, win); else passed++;
        consume_a();
    endtask

    task automatic test_mixed;
        int lat;
        job_a(pk4(1, 2, 3, 4), pk4(1, 3, 2, 5), lat);
        total++; if ({red, white, win} !== {3'd1, 3'd2, 1'b0}) $display("FAIL mixed_result got r%0d w%0d win%b want 1/2/0", red, white, win); else passed++;
        consume_a();
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        job_a(pk4(1, 2, 3, 4), pk4(1, 3, 2, 5), lat);
        @(negedge clock);
        in_valid = 1'b1; guess = pk4(7, 7, 7, 7); pattern = pk4(7, 7, 7, 7);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || red !== 3'd1 || white !== 3'd2 || win !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL hold_stable got %0d unstable cycles want 0 (last vld%b rdy%b r%0d w%0d)", bad, out_valid, in_ready, red, white); else passed++;
        // Consume with in_valid already high: that edge must not accept.
        @(negedge clock);
        out_ready = 1'b1; guess = pk4(4, 1, 2, 3); pattern = pk4(2, 4, 3, 1);
        @(posedge clock); #1 out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL consume_handshake got vld%b rdy%b want 0/1", out_valid, in_ready); else passed++;
        @(posedge clock); #1 in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL b2b_accept got rdy%b want 0", in_ready); else passed++;
        wait_a(lat);
        total++; if (lat !== 12) $display("FAIL b2b_latency got %0d want 12", lat); else passed++;
        total++; if ({red, white, win} !== {3'd0, 3'd4, 1'b0}) $display("FAIL b2b_result got r%0d w%0d win%b want 0/4/0", red, white, win); else passed++;
        consume_a();
    endtask

    task automatic test_async_reset;
        int lat;
        @(negedge clock);
        guess = pk4(1, 1, 1, 1); pattern = pk4(1, 1, 1, 1); in_valid = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL areset_handshake got vld%b rdy%b want 0/1", out_valid, in_ready); else passed++;
        total++; if ({red, white, win} !== 7'd0) $display("FAIL areset_result got r%0d w%0d win%b want 0/0/0", red, white, win); else passed++;
        @(negedge clock); reset = 1'b0;
        job_a(pk4(1, 2, 3, 4), pk4(1, 3, 2, 5), lat);
        total++; if (lat !== 12) $display("FAIL post_reset_latency got %0d want 12", lat); else passed++;
        total++; if ({red, white, win} !== {3'd1, 3'd2, 1'b0}) $display("FAIL post_reset_result got r%0d w%0d win%b want 1/2/0", red, white, win); else passed++;
        consume_a();
    endtask

    task automatic test_wide;
        int lat;
        // reds at pegs 0 and 5; leftovers guess{0,1,1,2} vs pattern{1,0,3,3} pair colours 0 and 1
        job_b(pk6(0, 0, 1, 1, 2, 3), pk6(0, 1, 0, 3, 3, 3), lat);
        total++; if (lat !== 10) $display("FAIL wide_latency got %0d want 10", lat); else passed++;
        total++; if ({b_red, b_white, b_win} !== {3'd2, 3'd2, 1'b0}) $display("FAIL wide_result got r%0d w%0d win%b want 2/2/0", b_red, b_white, b_win); else passed++;
        consume_b();
        job_b(pk6(3, 2, 1, 0, 3, 2), pk6(3, 2, 1, 0, 3, 2), lat);
        total++; if ({b_red, b_white, b_win} !== {3'd6, 3'd0, 1'b1}) $display("FAIL wide_win got r%0d w%0d win%b want 6/0/1", b_red, b_white, b_win); else passed++;
        consume_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_match();
        test_exact();
        test_duplicates();
        test_all_white();
        test_mixed();
        test_backpressure();
        test_async_reset();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
